// File: rtl/soc_pkg.sv
// Shared SoC definitions: UART slave register offsets, STATUS/CTRL bit positions
// and the transmit drain FSM encoding.
package soc_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_BUSY  = 3;
    localparam int ST_COUNT = 8;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_FLUSH = 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count; a push into a full FIFO is dropped
// and flush (pointers and count to zero) takes priority over push and pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmit buffer: bus writes queue bytes in a FIFO and a
// two-state drain FSM hands them one at a time to the uart transmitter.
module uart_tx_fifo
    import soc_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [7:0]  send_data_o,
    output logic        send_req_o,
    input  logic        tx_ready_i
);

    // Handshakes: gnt_o mirrors req_i, so every request is taken the cycle it is
    // presented; rvalid_o follows exactly one cycle later for reads and writes,
    // with rdata_o valid alongside it (zero for writes). On the uart side a launch
    // needs tx_ready_i high, send_req_o pulses for one cycle, and no new launch
    // happens until tx_ready_i has been seen low.
    logic [1:0]          reg_sel;
    logic                wr_acc;
    logic                rd_acc;
    logic                push;
    logic                flush;
    logic                launch;
    logic                enable;
    logic                overflow;
    logic                fifo_full;
    logic                fifo_empty;
    logic [7:0]          fifo_head;
    logic [CNT_BITS-1:0] fifo_count;
    logic [31:0]         status_word;
    logic [31:0]         read_mux;
    tx_state_e           state;
    logic                unused_bits;

    assign reg_sel     = addr_i[3:2];
    assign wr_acc      = req_i && we_i;
    assign rd_acc      = req_i && !we_i;
    assign push        = wr_acc && (reg_sel == REG_DATA) && be_i[0];
    assign flush       = wr_acc && (reg_sel == REG_CTRL) && wdata_i[CTRL_FLUSH];
    assign launch      = (state == IDLE) && enable && !fifo_empty && tx_ready_i;
    assign gnt_o       = req_i;
    assign unused_bits = &{1'b0, be_i[3:1], addr_i[31:4], addr_i[1:0], wdata_i[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (launch),
        .flush  (flush),
        .din    (wdata_i[7:0]),
        .dout   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        status_word                         = '0;
        status_word[ST_EMPTY]               = fifo_empty;
        status_word[ST_FULL]                = fifo_full;
        status_word[ST_OVF]                 = overflow;
        status_word[ST_BUSY]                = (state != IDLE);
        status_word[ST_COUNT +: CNT_BITS]   = fifo_count;
        read_mux                            = '0;
        case (reg_sel)
            REG_STATUS: read_mux          = status_word;
            REG_CTRL:   read_mux[CTRL_EN] = enable;
            default:    read_mux          = '0;
        endcase
    end

    // A push that finds the FIFO full is lost even if the FSM pops in that cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_acc && (reg_sel == REG_CTRL)) enable <= wdata_i[CTRL_EN];
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_acc && (reg_sel == REG_STATUS) && wdata_i[ST_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rd_acc ? read_mux : '0;
        end
    end

    // WAIT holds off the next launch until the uart has visibly taken the byte.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            send_req_o  <= 1'b0;
            send_data_o <= '0;
        end else begin
            send_req_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        send_req_o  <= 1'b1;
                        send_data_o <= fifo_head;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (!tx_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: register-map vector table, directed
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [7:0]  send_data_o;
    logic        send_req_o;
    logic        tx_ready_i;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_i       (req_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .send_data_o (send_data_o),
        .send_req_o  (send_req_o),
        .tx_ready_i  (tx_ready_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: bytes accepted but not yet sent, sticky overflow, enable.
    logic [7:0] exp_q[$];
    bit model_ovf = 1'b0;
    bit model_en = 1'b1;

    // uart model: ready drops the cycle after a send and stays low for a frame.
    bit uart_hold = 1'b1;
    bit uart_busy = 1'b0;
    bit uart_accept = 1'b0;
    int frame_cnt = 0;
    int frame_len = 3;
    int n_sends = 0;

    assign tx_ready_i = !uart_busy && !uart_hold;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[0] = (exp_q.size() == 0);
        s[1] = (exp_q.size() == DEPTH);
        s[2] = model_ovf;
        s[8 +: 5] = 5'(exp_q.size());
        return s;
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
        case (a)
            2'd0: if (b[0]) begin
                if (exp_q.size() == DEPTH) model_ovf = 1'b1;
                else exp_q.push_back(d[7:0]);
            end
            2'd1: if (d[2]) model_ovf = 1'b0;
            2'd2: begin
                model_en = d[0];
                if (d[1]) exp_q.delete();
            end
            default: ;
        endcase
    endfunction

    task automatic uart_model();
        bit busy_prev;
        bit accept_prev;
        forever begin
            @(negedge clk);
            busy_prev = uart_busy;
            accept_prev = uart_accept;
            if (uart_accept) begin
                uart_accept = 1'b0;
                uart_busy = 1'b1;
                frame_cnt = frame_len;
            end else if (uart_busy) begin
                if (frame_cnt == 0) uart_busy = 1'b0;
                else frame_cnt--;
            end
            if (send_req_o === 1'b1) begin
                n_sends++;
                uart_accept = 1'b1;
                check("dup_or_busy_send", 32'(busy_prev | accept_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_send actual=0x%02h required=no_send", send_data_o);
                end else begin
                    check("send_data", 32'(send_data_o), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge on which rvalid_o is sampled.
    task automatic bus_access(input logic w, input logic [1:0] a, input logic [3:0] b,
                              input logic [31:0] d, output logic [31:0] rd, output logic [31:0] snap);
        req_i = 1'b1;
        we_i = w;
        be_i = b;
        addr_i = 32'h2000_0000 | 32'({a, 2'b00});
        wdata_i = d;
        #1;
        check("gnt", 32'(gnt_o), 32'd1);
        @(posedge clk);
        snap = model_status();
        #1;
        if (w) model_write(a, b, d);
        @(negedge clk);
        check("rvalid", 32'(rvalid_o), 32'd1);
        rd = rdata_o;
        if (w) check("wr_rdata_zero", rdata_o, 32'd0);
        req_i = 1'b0;
        we_i = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic [31:0] snap;
        bus_access(1'b1, a, 4'hF, d, rd, snap);
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic [31:0] snap;
        bus_access(1'b0, a, 4'h0, 32'd0, rd, snap);
        check(name, rd, exp);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || uart_busy || uart_accept) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] snap;
        int s0;
        int op;

        vecs[0]  = '{1'b0, 2'd1, 4'h0, 32'h0,         32'h0000_0001};
        vecs[1]  = '{1'b1, 2'd0, 4'hE, 32'h0000_0077, 32'h0};
        vecs[2]  = '{1'b0, 2'd1, 4'h0, 32'h0,         32'h0000_0001};
        vecs[3]  = '{1'b0, 2'd0, 4'h0, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 2'd2, 4'h0, 32'h0,         32'h0000_0001};
        vecs[5]  = '{1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{1'b0, 2'd3, 4'h0, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 2'd0, 4'h1, 32'h0000_00AB, 32'h0};
        vecs[8]  = '{1'b0, 2'd1, 4'h0, 32'h0,         32'h0000_0100};
        vecs[9]  = '{1'b1, 2'd2, 4'hF, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 2'd2, 4'h0, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 2'd1, 4'hF, 32'h0000_0004, 32'h0};
        vecs[12] = '{1'b1, 2'd2, 4'hF, 32'h0000_0003, 32'h0};
        vecs[13] = '{1'b0, 2'd1, 4'h0, 32'h0,         32'h0000_0001};
        vecs[14] = '{1'b0, 2'd2, 4'h0, 32'h0,         32'h0000_0001};
        vecs[15] = '{1'b1, 2'd0, 4'hF, 32'h1234_56C3, 32'h0};
        vecs[16] = '{1'b0, 2'd1, 4'h0, 32'h0,         32'h0000_0100};
        vecs[17] = '{1'b1, 2'd2, 4'hF, 32'h0000_0002, 32'h0};
        vecs[18] = '{1'b0, 2'd1, 4'h0, 32'h0,         32'h0000_0001};
        vecs[19] = '{1'b0, 2'd2, 4'h0, 32'h0,         32'h0};
        vecs[20] = '{1'b1, 2'd2, 4'hF, 32'h0000_0001, 32'h0};

        fork
            uart_model();
        join_none

        // Reset state
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_send_req", 32'(send_req_o), 32'd0);
        check("rst_send_data", 32'(send_data_o), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Register map vectors, uart held not-ready
        for (int i = 0; i < 21; i++) begin
            bus_access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, snap);
            check($sformatf("vec%0d", i), rd, vecs[i].exp_rd);
        end

        // Single byte: launch one cycle after the push edge, busy until ready drops
        uart_hold = 1'b0;
        s0 = n_sends;
        wr(2'd0, 32'h41);
        check("single_not_early", 32'(send_req_o), 32'd0);
        @(negedge clk);
        check("single_send_req", 32'(send_req_o), 32'd1);
        check("single_send_data", 32'(send_data_o), 32'h41);
        rd_check("single_busy", 2'd1, 32'h0000_0009);
        wait_drain(60);
        check("single_count", 32'(n_sends - s0), 32'd1);
        rd_check("single_idle", 2'd1, 32'h0000_0001);

        // Burst fill, overflow, overflow clear, then drain in order
        uart_hold = 1'b1;
        for (int b = 8'h30; b <= 8'h3F; b++) wr(2'd0, 32'(b));
        rd_check("burst_full", 2'd1, 32'h0000_1002);
        wr(2'd0, 32'h99);
        rd_check("ovf_set", 2'd1, 32'h0000_1006);
        wr(2'd1, 32'h4);
        rd_check("ovf_clear", 2'd1, 32'h0000_1002);
        s0 = n_sends;
        uart_hold = 1'b0;
        wait_drain(16 * (frame_len + 8) + 50);
        check("burst_sends", 32'(n_sends - s0), 32'd16);
        rd_check("burst_done", 2'd1, 32'h0000_0001);

        // Enable off blocks launches; flush discards queued bytes
        wr(2'd2, 32'h0);
        s0 = n_sends;
        wr(2'd0, 32'h55);
        wr(2'd0, 32'h66);
        repeat (10) @(negedge clk);
        check("disabled_no_send", 32'(n_sends - s0), 32'd0);
        rd_check("disabled_count", 2'd1, 32'h0000_0200);
        wr(2'd2, 32'h3);
        rd_check("flushed", 2'd1, 32'h0000_0001);
        repeat (10) @(negedge clk);
        check("flushed_no_send", 32'(n_sends - s0), 32'd0);
        rd_check("ctrl_enabled", 2'd2, 32'h0000_0001);

        // Push and pop in the same cycle
        uart_hold = 1'b1;
        wr(2'd0, 32'hA1);
        rd_check("pp_pre", 2'd1, 32'h0000_0100);
        uart_hold = 1'b0;
        s0 = n_sends;
        wr(2'd0, 32'hB2);
        check("pp_send_req", 32'(send_req_o), 32'd1);
        check("pp_send_head", 32'(send_data_o), 32'hA1);
        rd_check("pp_count", 2'd1, 32'h0000_0108);
        wait_drain(60);
        check("pp_sends", 32'(n_sends - s0), 32'd2);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) uart_hold = !uart_hold;
            frame_len = $urandom_range(0, 4);
            op = $urandom_range(0, 99);
            if (op < 55) begin
                bus_access(1'b1, 2'd0, 4'($urandom_range(0, 15)), $urandom, rd, snap);
            end else if (op < 72) begin
                bus_access(1'b0, 2'd1, 4'h0, 32'd0, rd, snap);
                check("rand_status", rd & ~32'h8, snap);
            end else if (op < 78) begin
                bus_access(1'b1, 2'd1, 4'hF, $urandom, rd, snap);
            end else if (op < 85) begin
                if (!model_en && $urandom_range(0, 1) == 1)
                    wr(2'd2, 32'h2 | 32'($urandom_range(0, 1)));
                else
                    wr(2'd2, 32'($urandom_range(0, 3) != 0));
            end else if (op < 91) begin
                rd_check("rand_ctrl", 2'd2, 32'(model_en));
            end else if (op < 95) begin
                bus_access(1'b0, 2'($urandom_range(0, 1) * 3), 4'h0, 32'd0, rd, snap);
                check("rand_data_rsvd", rd, 32'd0);
            end else begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        uart_hold = 1'b0;
        wr(2'd2, 32'h1);
        wait_drain(DEPTH * 12 + 100);
        check("rand_all_sent", 32'(exp_q.size()), 32'd0);
        bus_access(1'b0, 2'd1, 4'h0, 32'd0, rd, snap);
        check("rand_final_status", rd, snap);

        // Asynchronous reset mid-cycle with bytes queued
        uart_hold = 1'b1;
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        wr(2'd0, 32'h33);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rvalid", 32'(rvalid_o), 32'd0);
        check("async_rdata", rdata_o, 32'd0);
        check("async_send_req", 32'(send_req_o), 32'd0);
        check("async_send_data", 32'(send_data_o), 32'd0);
        exp_q.delete();
        model_ovf = 1'b0;
        model_en = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        rd_check("post_reset_status", 2'd1, 32'h0000_0001);
        rd_check("post_reset_ctrl", 2'd2, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
